// File: rtl/udp_pkg.sv
// Shared definitions for the UDP reader/writer pair: state encoding and field widths.
package udp_pkg;

    localparam int unsigned DRAW_BOX_DATA_BYTE = 6;
    localparam int unsigned INDEX_W            = 16;
    localparam int unsigned LEN_W              = 16;
    localparam int unsigned BYTE_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_SEND
    } udp_wr_state_e;

endpackage

// File: rtl/udp_writer_payload_shifter.sv
// Loadable byte-wide shift register; the top byte is the next byte to transmit.
module payload_shifter
    import udp_pkg::*;
#(
    parameter int unsigned CAPACITY = DRAW_BOX_DATA_BYTE
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         load,
    input  logic                         shift,
    input  logic [CAPACITY*BYTE_W-1:0]   din,
    output logic [BYTE_W-1:0]            top_byte
);

    localparam int unsigned DATA_W = CAPACITY * BYTE_W;

    logic [DATA_W-1:0] sreg;

    // Shift towards the MSB end and zero-fill so drained bytes read as 0x00.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << BYTE_W;
        end
    end

    assign top_byte = sreg[DATA_W-1 -: BYTE_W];

endmodule

// File: rtl/udp_writer.sv
// Latches a payload, requests a UDP frame with trig and streams bytes on read_en.
// Optional XOR trailer byte enabled by defining UDP_WRITER_CHECKSUM_EN.
module udp_writer
    import udp_pkg::*;
#(
    parameter int unsigned CAPACITY = DRAW_BOX_DATA_BYTE,
    parameter int unsigned TIMEOUT  = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        send,
    input  logic [CAPACITY*BYTE_W-1:0]  i_data,
    input  logic [LEN_W-1:0]            i_len,
    input  logic                        read_en,
    output logic                        trig,
    output logic [INDEX_W-1:0]          index,
    output logic [BYTE_W-1:0]           o_data,
    output logic [LEN_W-1:0]            o_len,
    output logic                        busy,
    output logic                        error
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    udp_wr_state_e      state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [LEN_W-1:0]   ptr, ptr_d;
    logic [LEN_W-1:0]   o_len_d;
    logic [INDEX_W-1:0] index_d;
    logic [BYTE_W-1:0]  o_data_d;
    logic               trig_d, busy_d, error_d;
    logic               load, shift;
    logic               len_ok_c, last_c;
    logic [BYTE_W-1:0]  top_byte, pull_byte_c;

`ifdef UDP_WRITER_CHECKSUM_EN
    logic [LEN_W-1:0]   plen, plen_d;
    logic [BYTE_W-1:0]  csum, csum_d, payload_xor_c;

    // XOR of the bytes about to be latched, so the trailer is ready before streaming.
    always_comb begin
        payload_xor_c = '0;
        for (int unsigned i = 0; i < CAPACITY; i++) begin
            if (i < 32'(i_len)) begin
                payload_xor_c = payload_xor_c ^ i_data[(CAPACITY-i)*BYTE_W-1 -: BYTE_W];
            end
        end
    end

    assign pull_byte_c = (ptr < plen) ? top_byte : csum;
`else
    assign pull_byte_c = top_byte;
`endif

    assign len_ok_c = (i_len != '0) && (32'(i_len) <= CAPACITY);
    assign last_c   = (ptr == o_len - LEN_W'(1));

    payload_shifter #(
        .CAPACITY (CAPACITY)
    ) u_shifter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .shift    (shift),
        .din      (i_data),
        .top_byte (top_byte)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ptr_d    = ptr;
        o_len_d  = o_len;
        index_d  = index;
        o_data_d = o_data;
        error_d  = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
`ifdef UDP_WRITER_CHECKSUM_EN
        plen_d   = plen;
        csum_d   = csum;
`endif

        case (state)
            ST_IDLE: begin
                if (read_en) begin
                    o_data_d = '0;
                end
                if (send) begin
                    if (len_ok_c) begin
                        load    = 1'b1;
                        ptr_d   = '0;
                        state_d = ST_TRIG;
`ifdef UDP_WRITER_CHECKSUM_EN
                        o_len_d = i_len + LEN_W'(1);
                        plen_d  = i_len;
                        csum_d  = payload_xor_c;
`else
                        o_len_d = i_len;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_TRIG: begin
                error_d = send;
                if (read_en) begin
                    o_data_d = '0;
                end
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                error_d = send;
                if (read_en) begin
                    o_data_d = pull_byte_c;
                    shift    = 1'b1;
                    ptr_d    = ptr + LEN_W'(1);
                    if (last_c) begin
                        state_d = ST_IDLE;
                        index_d = index + INDEX_W'(1);
                    end else begin
                        state_d = ST_SEND;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            ST_SEND: begin
                error_d = send;
                if (read_en) begin
                    o_data_d = pull_byte_c;
                    shift    = 1'b1;
                    ptr_d    = ptr + LEN_W'(1);
                    if (last_c) begin
                        state_d = ST_IDLE;
                        index_d = index + INDEX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        trig_d = (state_d == ST_TRIG);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            o_len  <= '0;
            index  <= '0;
            o_data <= '0;
            trig   <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            ptr    <= ptr_d;
            o_len  <= o_len_d;
            index  <= index_d;
            o_data <= o_data_d;
            trig   <= trig_d;
            busy   <= busy_d;
            error  <= error_d;
        end
    end

`ifdef UDP_WRITER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            plen <= '0;
            csum <= '0;
        end else begin
            plen <= plen_d;
            csum <= csum_d;
        end
    end
`endif

endmodule

// File: tb/tb_udp_writer.sv
// Bench for udp_writer: directed vector table plus random traffic against a queue-based model.
module tb_udp_writer;

    localparam int unsigned CAP = 6;
    localparam int unsigned TMO = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            send;
    logic [CAP*8-1:0] i_data;
    logic [15:0]     i_len;
    logic            read_en;
    logic            trig;
    logic [15:0]     index;
    logic [7:0]      o_data;
    logic [15:0]     o_len;
    logic            busy;
    logic            error;

    udp_writer #(
        .CAPACITY (CAP),
        .TIMEOUT  (TMO)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .send    (send),
        .i_data  (i_data),
        .i_len   (i_len),
        .read_en (read_en),
        .trig    (trig),
        .index   (index),
        .o_data  (o_data),
        .o_len   (o_len),
        .busy    (busy),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is a queue of bytes still owed to the packet builder.
    bit          m_active;
    int          m_phase;      // 1: trig cycle, 2: waiting first pull, 3: streaming
    int          m_wait;
    logic [7:0]  m_q[$];
    logic [7:0]  m_od;
    logic [15:0] m_idx;
    logic [15:0] m_olen;
    bit          m_err;

    typedef struct {
        logic        s;
        logic [15:0] len;
        logic [47:0] d;
        logic        re;
        logic        trig;
        logic        busy;
        logic        err;
        logic [7:0]  od;
        logic [15:0] idx;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_phase  = 0;
        m_wait   = 0;
        m_q.delete();
        m_od     = 8'h00;
        m_idx    = 16'h0000;
        m_olen   = 16'h0000;
        m_err    = 1'b0;
    endtask

    task automatic model_pull();
        m_od    = m_q.pop_front();
        m_phase = 3;
        if (m_q.size() == 0) begin
            m_active = 1'b0;
            m_idx    = m_idx + 16'd1;
        end
    endtask

    task automatic model_edge(input bit s, input logic [15:0] len, input logic [47:0] d, input bit re);
        logic [7:0] b, x;
        m_err = 1'b0;
        if (!m_active) begin
            if (re) m_od = 8'h00;
            if (s) begin
                if (len >= 1 && len <= CAP) begin
                    m_q.delete();
                    x = 8'h00;
                    for (int i = 0; i < int'(len); i++) begin
                        b = d[(CAP-i)*8-1 -: 8];
                        m_q.push_back(b);
                        x = x ^ b;
                    end
`ifdef UDP_WRITER_CHECKSUM_EN
                    m_q.push_back(x);
`endif
                    m_olen   = 16'(m_q.size());
                    m_active = 1'b1;
                    m_phase  = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            if (s) m_err = 1'b1;
            if (m_phase == 1) begin
                if (re) m_od = 8'h00;
                m_phase = 2;
                m_wait  = 0;
            end else if (m_phase == 2) begin
                if (re) begin
                    model_pull();
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_err    = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else begin
                if (re) model_pull();
            end
        end
    endtask

    task automatic check_all();
        chk("trig",   64'(trig),   64'(m_active && m_phase == 1));
        chk("busy",   64'(busy),   64'(m_active));
        chk("error",  64'(error),  64'(m_err));
        chk("o_data", 64'(o_data), 64'(m_od));
        chk("index",  64'(index),  64'(m_idx));
        chk("o_len",  64'(o_len),  64'(m_olen));
    endtask

    // One clock of stimulus, model update and full comparison.
    task automatic cyc(input bit s, input logic [15:0] len, input logic [47:0] d, input bit re);
        send    = s;
        i_len   = len;
        i_data  = d;
        read_en = re;
        @(posedge clk);
        model_edge(s, len, d, re);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        send = 1'b0; read_en = 1'b0; i_len = '0; i_data = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    localparam logic [47:0] P1 = 48'h0102_0304_0506;
    localparam logic [47:0] PF = 48'hFFFF_FFFF_FFFF;

    initial begin
        int          first_err;
        int          prob;
        logic [63:0] rnd;

        // Directed vectors for the basic frame and rejected sends.
        tbl[0]  = '{1'b1, 16'd6, P1,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
        tbl[1]  = '{1'b0, 16'd0, '0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
        tbl[2]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 16'd0};
        tbl[3]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 16'd0};
        tbl[4]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 16'd0};
        tbl[5]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 16'd0};
        tbl[6]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 16'd0};
`ifdef UDP_WRITER_CHECKSUM_EN
        tbl[7]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b1, 1'b0, 8'h06, 16'd0};
        tbl[8]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 16'd1};
`else
        tbl[7]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 16'd1};
        tbl[8]  = '{1'b0, 16'd0, '0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
`endif
        tbl[9]  = '{1'b1, 16'd0, P1,  1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd1};
        tbl[10] = '{1'b1, 16'd7, P1,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd1};
        tbl[11] = '{1'b0, 16'd0, '0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};

        send = 1'b0; read_en = 1'b0; i_len = '0; i_data = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trig",   64'(trig),   64'd0);
        chk("rst_index",  64'(index),  64'd0);
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_o_len",  64'(o_len),  64'd0);
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_error",  64'(error),  64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send = tbl[i].s; i_len = tbl[i].len; i_data = tbl[i].d; read_en = tbl[i].re;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_trig", i),   64'(trig),   64'(tbl[i].trig));
            chk($sformatf("v%0d_busy", i),   64'(busy),   64'(tbl[i].busy));
            chk($sformatf("v%0d_error", i),  64'(error),  64'(tbl[i].err));
            chk($sformatf("v%0d_o_data", i), 64'(o_data), 64'(tbl[i].od));
            chk($sformatf("v%0d_index", i),  64'(index),  64'(tbl[i].idx));
        end

        // Timeout: no pull after trig.
        do_reset();
        cyc(1'b1, 16'd6, P1, 1'b0);
        first_err = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b0, 16'd0, '0, 1'b0);
            if (error && first_err < 0) first_err = k;
        end
        chk("timeout_latency", 64'(first_err), 64'(TMO + 1));
        chk("timeout_index",   64'(index),     64'd0);

        // Send while streaming must not disturb the latched payload.
        cyc(1'b1, 16'd6, P1, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b1, 16'd6, PF, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 16'd0, '0, 1'b1);

        // Every-other-cycle pulls, then two extra pulls after the frame.
        cyc(1'b1, 16'd5, 48'hA1B2_C3D4_E5F6, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b0, 16'd0, '0, k % 2 == 0);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b0, 16'd0, '0, 1'b1);

        // Single-byte frame and a new send right after busy falls.
        cyc(1'b1, 16'd1, 48'h7700_0000_0000, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b1, 16'd2, 48'h1122_0000_0000, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b0, 16'd0, '0, 1'b1);

        // Reset mid-frame: remaining pulls must read 0x00.
        cyc(1'b1, 16'd6, P1, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b0);
        cyc(1'b0, 16'd0, '0, 1'b1);
        cyc(1'b0, 16'd0, '0, 1'b1);
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_all();
        for (int k = 0; k < 4; k++) cyc(1'b0, 16'd0, '0, 1'b1);

        // Random traffic with varying pull density.
        for (int blk = 0; blk < 30; blk++) begin
            case ($urandom_range(0, 3))
                0:       prob = 0;
                1:       prob = 30;
                2:       prob = 70;
                default: prob = 100;
            endcase
            for (int k = 0; k < 100; k++) begin
                rnd = {$urandom, $urandom};
                cyc($urandom_range(0, 19) == 0, 16'($urandom_range(0, 7)), rnd[47:0],
                    $urandom_range(0, 99) < prob);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
